// File: rtl/multiplier_pipelined_param_if.sv
// Operand/result handshake bundle for multiplier_pipelined_param.
//   master : issue side (drives operands, tag, out_ready; sees in_ready and results)
//   slave  : multiplier side (accepts operands, returns r/out_tag with out_valid)
// Signals:
//   in_valid/in_ready   operand beat handshake
//   a, b                WIDTH-bit operands
//   is_signed           1 = two's-complement operands for this beat
//   in_tag              opaque tag returned with the result
//   out_valid/out_ready result handshake
//   r                   2*WIDTH-bit product
//   out_tag             tag of the result
interface multiplier_pipelined_param_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   is_signed;
    logic [TAG_WIDTH-1:0]   in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     r;
    logic [TAG_WIDTH-1:0]   out_tag;

    modport master (
        output in_valid, a, b, is_signed, in_tag, out_ready,
        input  in_ready, out_valid, r, out_tag
    );

    modport slave (
        input  in_valid, a, b, is_signed, in_tag, out_ready,
        output in_ready, out_valid, r, out_tag
    );
endinterface

// File: rtl/multiplier_pipelined_param.sv
// Three-stage pipelined WIDTH x WIDTH multiplier with per-beat signed/unsigned mode,
// a sideband tag and valid/ready handshakes on both sides.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset; clears all valid bits and data registers
//   bus    slave modport of multiplier_pipelined_param_if (operands in, product out)
// WIDTH must be even and >= 4; TAG_WIDTH must be >= 1.
// The whole pipe advances as one unit: when the result stage is full and not taken,
// every stage holds (bubbles are not squeezed out).
module multiplier_pipelined_param #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 4
) (
    input logic                         clk,
    input logic                         reset,
    multiplier_pipelined_param_if.slave bus
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned W2 = 2 * WIDTH;

    logic adv;

    // Stage 1: captured operands
    logic                 v1_q, v1_d;
    logic [WIDTH-1:0]     a1_q, a1_d;
    logic [WIDTH-1:0]     b1_q, b1_d;
    logic                 s1_q, s1_d;
    logic [TAG_WIDTH-1:0] tag1_q, tag1_d;

    // Stage 2: partial products and signed correction
    logic                 v2_q, v2_d;
    logic [WIDTH-1:0]     ll_q, ll_d;
    logic [WIDTH-1:0]     hl_q, hl_d;
    logic [WIDTH-1:0]     lh_q, lh_d;
    logic [WIDTH-1:0]     hh_q, hh_d;
    logic [W2-1:0]        corr_q, corr_d;
    logic [TAG_WIDTH-1:0] tag2_q, tag2_d;

    // Stage 3: result
    logic                 v3_q, v3_d;
    logic [W2-1:0]        r_q, r_d;
    logic [TAG_WIDTH-1:0] tag3_q, tag3_d;

    logic [H-1:0]     a_lo, a_hi, b_lo, b_hi;
    logic [WIDTH-1:0] corr_sum;
    logic [W2-1:0]    mid, prod;

    assign adv = !v3_q || bus.out_ready;

    always_comb begin : s1_next
        v1_d   = v1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        s1_d   = s1_q;
        tag1_d = tag1_q;
        if (adv) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                a1_d   = bus.a;
                b1_d   = bus.b;
                s1_d   = bus.is_signed;
                tag1_d = bus.in_tag;
            end
        end
    end

    always_comb begin : s2_next
        a_lo     = a1_q[H-1:0];
        a_hi     = a1_q[WIDTH-1:H];
        b_lo     = b1_q[H-1:0];
        b_hi     = b1_q[WIDTH-1:H];
        // Only the low WIDTH bits survive the << WIDTH into a 2*WIDTH result.
        corr_sum = (a1_q[WIDTH-1] ? b1_q : '0) + (b1_q[WIDTH-1] ? a1_q : '0);
        v2_d     = v2_q;
        ll_d     = ll_q;
        hl_d     = hl_q;
        lh_d     = lh_q;
        hh_d     = hh_q;
        corr_d   = corr_q;
        tag2_d   = tag2_q;
        if (adv) begin
            v2_d = v1_q;
            if (v1_q) begin
                ll_d   = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_lo};
                hl_d   = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_lo};
                lh_d   = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_hi};
                hh_d   = {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_hi};
                corr_d = s1_q ? {corr_sum, {WIDTH{1'b0}}} : '0;
                tag2_d = tag1_q;
            end
        end
    end

    always_comb begin : s3_next
        mid    = {{WIDTH{1'b0}}, hl_q} + {{WIDTH{1'b0}}, lh_q};
        // Unsigned product minus the sign correction gives the two's-complement
        // product modulo 2^(2*WIDTH).
        prod   = {hh_q, {WIDTH{1'b0}}} + (mid << H) + {{WIDTH{1'b0}}, ll_q} - corr_q;
        v3_d   = v3_q;
        r_d    = r_q;
        tag3_d = tag3_q;
        if (adv) begin
            v3_d = v2_q;
            // r/out_tag keep their last value across bubbles.
            if (v2_q) begin
                r_d    = prod;
                tag3_d = tag2_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            s1_q   <= 1'b0;
            tag1_q <= '0;
            v2_q   <= 1'b0;
            ll_q   <= '0;
            hl_q   <= '0;
            lh_q   <= '0;
            hh_q   <= '0;
            corr_q <= '0;
            tag2_q <= '0;
            v3_q   <= 1'b0;
            r_q    <= '0;
            tag3_q <= '0;
        end else begin
            v1_q   <= v1_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            s1_q   <= s1_d;
            tag1_q <= tag1_d;
            v2_q   <= v2_d;
            ll_q   <= ll_d;
            hl_q   <= hl_d;
            lh_q   <= lh_d;
            hh_q   <= hh_d;
            corr_q <= corr_d;
            tag2_q <= tag2_d;
            v3_q   <= v3_d;
            r_q    <= r_d;
            tag3_q <= tag3_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v3_q;
    assign bus.r         = r_q;
    assign bus.out_tag   = tag3_q;

endmodule

// File: tb/tb_multiplier_pipelined_param.sv
// Bench for multiplier_pipelined_param: a 32-bit/4-bit-tag instance and an
// 8-bit/1-bit-tag instance share clock and reset. Inputs change 2 time units after
// the rising edge; everything is sampled on the falling edge. A per-instance
// scoreboard queue gets the model product on every accepted beat and is checked on
// every taken result.
module tb_multiplier_pipelined_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multiplier_pipelined_param_if #(.WIDTH(32), .TAG_WIDTH(4)) bus32 ();
    multiplier_pipelined_param_if #(.WIDTH(8), .TAG_WIDTH(1)) bus8 ();

    multiplier_pipelined_param #(.WIDTH(32), .TAG_WIDTH(4)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    multiplier_pipelined_param #(.WIDTH(8), .TAG_WIDTH(1)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [67:0] q32[$];
    logic [16:0] q8[$];
    logic [67:0] e32;
    logic [16:0] e8;

    // Reference: sign- or zero-extend then multiply at full width.
    function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [63:0] ae, be;
        ae = s ? {{32{a[31]}}, a} : {32'h0, a};
        be = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ae * be;
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
        logic [15:0] ae, be;
        ae = s ? {{8{a[7]}}, a} : {8'h0, a};
        be = s ? {{8{b[7]}}, b} : {8'h0, b};
        return ae * be;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus32.in_valid && bus32.in_ready)
                q32.push_back({model32(bus32.a, bus32.b, bus32.is_signed), bus32.in_tag});
            if (bus32.out_valid && bus32.out_ready) begin
                total++;
                if (q32.size() == 0) begin
                    bad++;
                    $display("FAIL sb32_unexpected got r=%h tag=%0d want no result",
                             bus32.r, bus32.out_tag);
                end else begin
                    e32 = q32.pop_front();
                    if ({bus32.r, bus32.out_tag} !== e32) begin
                        bad++;
                        $display("FAIL sb32 got r=%h tag=%0d want r=%h tag=%0d",
                                 bus32.r, bus32.out_tag, e32[67:4], e32[3:0]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus8.in_valid && bus8.in_ready)
                q8.push_back({model8(bus8.a, bus8.b, bus8.is_signed), bus8.in_tag});
            if (bus8.out_valid && bus8.out_ready) begin
                total++;
                if (q8.size() == 0) begin
                    bad++;
                    $display("FAIL sb8_unexpected got r=%h tag=%0d want no result",
                             bus8.r, bus8.out_tag);
                end else begin
                    e8 = q8.pop_front();
                    if ({bus8.r, bus8.out_tag} !== e8) begin
                        bad++;
                        $display("FAIL sb8 got r=%h tag=%0d want r=%h tag=%0d",
                                 bus8.r, bus8.out_tag, e8[16:1], e8[0]);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset           = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.a         = '0;
        bus32.b         = '0;
        bus32.is_signed = 1'b0;
        bus32.in_tag    = '0;
        bus32.out_ready = 1'b1;
        bus8.in_valid   = 1'b0;
        bus8.a          = '0;
        bus8.b          = '0;
        bus8.is_signed  = 1'b0;
        bus8.in_tag     = '0;
        bus8.out_ready  = 1'b1;
        #12;
        total++;
        if (bus32.out_valid !== 1'b0 || bus32.r !== 64'h0 || bus32.out_tag !== 4'h0) begin
            bad++;
            $display("FAIL reset32_state got v=%b r=%h tag=%0d want v=0 r=0 tag=0",
                     bus32.out_valid, bus32.r, bus32.out_tag);
        end
        total++;
        if (bus8.out_valid !== 1'b0 || bus8.r !== 16'h0 || bus8.out_tag !== 1'b0) begin
            bad++;
            $display("FAIL reset8_state got v=%b r=%h tag=%0d want v=0 r=0 tag=0",
                     bus8.out_valid, bus8.r, bus8.out_tag);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset32_ready got in_ready=%b v=%b want in_ready=1 v=0",
                     bus32.in_ready, bus32.out_valid);
        end
        total++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset8_ready got in_ready=%b v=%b want in_ready=1 v=0",
                     bus8.in_ready, bus8.out_valid);
        end
    endtask

    task automatic test_unsigned_basic();
        @(posedge clk);
        #2;
        bus32.a         = 32'hFFFF_FFFF;
        bus32.b         = 32'hFFFF_FFFF;
        bus32.is_signed = 1'b0;
        bus32.in_tag    = 4'd3;
        bus32.in_valid  = 1'b1;
        @(posedge clk);
        #2 bus32.in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (bus32.out_valid !== (k == 3)) begin
                bad++;
                $display("FAIL unsigned_latency cycle=%0d got v=%b want v=%b",
                         k, bus32.out_valid, (k == 3));
            end
        end
        total++;
        if (bus32.r !== 64'hFFFF_FFFE_0000_0001 || bus32.out_tag !== 4'd3) begin
            bad++;
            $display("FAIL unsigned_value got r=%h tag=%0d want r=fffffffe00000001 tag=3",
                     bus32.r, bus32.out_tag);
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [63:0] tr [3];
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; tr[0] = 64'h0000_0000_0000_0001;
        ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000; tr[1] = 64'h4000_0000_0000_0000;
        ta[2] = 32'h8000_0000; tb[2] = 32'h0000_0002; tr[2] = 64'hFFFF_FFFF_0000_0000;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #2;
            if (c < 3) begin
                bus32.a         = ta[c];
                bus32.b         = tb[c];
                bus32.is_signed = 1'b1;
                bus32.in_tag    = 4'(c + 8);
                bus32.in_valid  = 1'b1;
            end else begin
                bus32.in_valid = 1'b0;
            end
            @(negedge clk);
            total++;
            if (bus32.out_valid !== (c >= 3)) begin
                bad++;
                $display("FAIL signed_valid cycle=%0d got v=%b want v=%b",
                         c, bus32.out_valid, (c >= 3));
            end
            if (c >= 3) begin
                total++;
                if (bus32.r !== tr[c-3]) begin
                    bad++;
                    $display("FAIL signed_value beat=%0d got r=%h want r=%h",
                             c - 3, bus32.r, tr[c-3]);
                end
            end
        end
    endtask

    task automatic test_streaming();
        for (int c = 0; c < 11; c++) begin
            @(posedge clk);
            #2;
            if (c < 8) begin
                bus32.a         = 32'(c);
                bus32.b         = 32'(c + 1);
                bus32.is_signed = c[0];
                bus32.in_tag    = 4'(c);
                bus32.in_valid  = 1'b1;
            end else begin
                bus32.in_valid = 1'b0;
            end
            @(negedge clk);
            total++;
            if (bus32.in_ready !== 1'b1 || bus32.out_valid !== (c >= 3)) begin
                bad++;
                $display("FAIL stream_flow cycle=%0d got in_ready=%b v=%b want in_ready=1 v=%b",
                         c, bus32.in_ready, bus32.out_valid, (c >= 3));
            end
            if (c >= 3) begin
                total++;
                if (bus32.r !== 64'((c - 3) * (c - 2)) || bus32.out_tag !== 4'(c - 3)) begin
                    bad++;
                    $display("FAIL stream_value beat=%0d got r=%h tag=%0d want r=%h tag=%0d",
                             c - 3, bus32.r, bus32.out_tag, 64'((c - 3) * (c - 2)), c - 3);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        logic        ps [4];
        pa[0] = 32'h1234_5678; pb[0] = 32'h9ABC_DEF0; ps[0] = 1'b1;
        pa[1] = 32'h0000_FFFF; pb[1] = 32'hFFFF_0000; ps[1] = 1'b0;
        pa[2] = 32'h7FFF_FFFF; pb[2] = 32'h8000_0001; ps[2] = 1'b1;
        pa[3] = 32'hDEAD_BEEF; pb[3] = 32'h0000_0013; ps[3] = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #2;
            if (c < 4 || c == 8) begin
                bus32.a         = pa[c < 4 ? c : 3];
                bus32.b         = pb[c < 4 ? c : 3];
                bus32.is_signed = ps[c < 4 ? c : 3];
                bus32.in_tag    = 4'(c < 4 ? c + 1 : 4);
                bus32.in_valid  = 1'b1;
            end else if (c > 8) begin
                bus32.in_valid = 1'b0;
            end
            bus32.out_ready = !(c >= 3 && c <= 7);
            @(negedge clk);
            if (c >= 3 && c <= 7) begin
                total++;
                if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1 ||
                    bus32.r !== model32(pa[0], pb[0], ps[0]) || bus32.out_tag !== 4'd1) begin
                    bad++;
                    $display("FAIL stall_hold cycle=%0d got in_ready=%b v=%b r=%h tag=%0d want in_ready=0 v=1 r=%h tag=1",
                             c, bus32.in_ready, bus32.out_valid, bus32.r, bus32.out_tag,
                             model32(pa[0], pb[0], ps[0]));
                end
            end
            if (c == 8) begin
                total++;
                if (bus32.in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_release got in_ready=%b want 1", bus32.in_ready);
                end
            end
        end
        total++;
        if (q32.size() != 0 || bus32.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_drain got pending=%0d v=%b want pending=0 v=0",
                     q32.size(), bus32.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #2;
            bus32.a         = 32'd5 + 32'(c);
            bus32.b         = 32'd9;
            bus32.is_signed = 1'b0;
            bus32.in_tag    = 4'(c + 1);
            bus32.in_valid  = 1'b1;
        end
        @(posedge clk);
        #2 bus32.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        q32.delete();
        q8.delete();
        total++;
        if (bus32.out_valid !== 1'b0 || bus32.r !== 64'h0 || bus32.out_tag !== 4'h0) begin
            bad++;
            $display("FAIL midreset_clear got v=%b r=%h tag=%0d want v=0 r=0 tag=0",
                     bus32.out_valid, bus32.r, bus32.out_tag);
        end
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (bus32.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL midreset_stale cycle=%0d got v=%b want v=0", c, bus32.out_valid);
            end
        end
        @(posedge clk);
        #2;
        bus32.a         = 32'd7;
        bus32.b         = 32'd6;
        bus32.in_tag    = 4'd5;
        bus32.in_valid  = 1'b1;
        @(posedge clk);
        #2 bus32.in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (bus32.out_valid !== (k == 3)) begin
                bad++;
                $display("FAIL midreset_latency cycle=%0d got v=%b want v=%b",
                         k, bus32.out_valid, (k == 3));
            end
        end
        total++;
        if (bus32.r !== 64'd42 || bus32.out_tag !== 4'd5) begin
            bad++;
            $display("FAIL midreset_value got r=%h tag=%0d want r=42 tag=5",
                     bus32.r, bus32.out_tag);
        end
    endtask

    task automatic test_param8();
        logic [7:0]  ta [3];
        logic [7:0]  tb [3];
        logic        ts [3];
        logic [15:0] tr [3];
        int          accepted;
        int          cycles;
        logic        taken;
        ta[0] = 8'hFF; tb[0] = 8'hFF; ts[0] = 1'b0; tr[0] = 16'hFE01;
        ta[1] = 8'hFF; tb[1] = 8'hFF; ts[1] = 1'b1; tr[1] = 16'h0001;
        ta[2] = 8'h80; tb[2] = 8'h80; ts[2] = 1'b1; tr[2] = 16'h4000;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #2;
            if (c < 3) begin
                bus8.a         = ta[c];
                bus8.b         = tb[c];
                bus8.is_signed = ts[c];
                bus8.in_tag    = c[0];
                bus8.in_valid  = 1'b1;
            end else begin
                bus8.in_valid = 1'b0;
            end
            @(negedge clk);
            total++;
            if (bus8.out_valid !== (c >= 3)) begin
                bad++;
                $display("FAIL p8_valid cycle=%0d got v=%b want v=%b", c, bus8.out_valid, (c >= 3));
            end
            if (c >= 3) begin
                total++;
                if (bus8.r !== tr[c-3]) begin
                    bad++;
                    $display("FAIL p8_value beat=%0d got r=%h want r=%h", c - 3, bus8.r, tr[c-3]);
                end
            end
        end
        accepted = 0;
        cycles   = 0;
        taken    = 1'b0;
        while (accepted < 1000 && cycles < 20000) begin
            @(posedge clk);
            #2;
            cycles++;
            if (!bus8.in_valid || taken) begin
                bus8.in_valid  = ($urandom_range(0, 3) != 0);
                bus8.a         = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                bus8.b         = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                bus8.is_signed = 1'($urandom);
                bus8.in_tag    = 1'($urandom);
            end
            bus8.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            taken = bus8.in_valid && bus8.in_ready;
            if (taken) accepted++;
        end
        @(posedge clk);
        #2;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (accepted != 1000 || q8.size() != 0) begin
            bad++;
            $display("FAIL p8_random got accepted=%0d pending=%0d want accepted=1000 pending=0",
                     accepted, q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_streaming();
        test_backpressure();
        test_reset_mid();
        test_param8();
        repeat (4) @(negedge clk);
        total++;
        if (q32.size() != 0) begin
            bad++;
            $display("FAIL sb32_leftover got pending=%0d want 0", q32.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
